// File: rtl/ring_mon_pkg.sv
// Shared definitions for the ring monitor: FSM state encoding, default sizes
// and the rotate-left helper used to predict the next legal ring word.
package ring_mon_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_REV_W     = 8;
    localparam int DEF_STALL_LIM = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        FAULT    = 2'd3
    } state_t;

    // Rotates the low 'width' bits of value left by one; bits above width must be zero.
    function automatic logic [63:0] rotl(input logic [63:0] value, input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        rotl = ((value << 1) | (value >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Bus between a ring counter consumer and the ring monitor: the ring word and
// clear go in, position/lock/revolution/fault status comes out.
interface ring_monitor_if import ring_mon_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int REV_W = DEF_REV_W
) ();

    localparam int POS_W = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             sync_clr;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             locked;
    logic [REV_W-1:0] rev_count;
    logic             rev_tick;
    logic             err_onehot;
    logic             err_seq;
    logic             err_stall;

    modport master (
        output ring_in, sync_clr,
        input  pos, pos_valid, locked, rev_count, rev_tick,
        input  err_onehot, err_seq, err_stall
    );

    modport slave (
        input  ring_in, sync_clr,
        output pos, pos_valid, locked, rev_count, rev_tick,
        output err_onehot, err_seq, err_stall
    );

endinterface

// File: rtl/ring_monitor_onehot_enc.sv
// Combinational one-hot checker and encoder: flags a word with exactly one set
// bit and reports the index of the highest set bit.
module onehot_enc #(
    parameter  int WIDTH = 4,
    localparam int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_onehot,
    output logic [POS_W-1:0] o_index
);

    always_comb begin
        o_onehot = ($countones(i_word) == 1);
        o_index  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_word[i]) begin
                o_index = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/ring_monitor.sv
// Ring counter monitor: checks one-hot legality and rotate-left sequencing,
// counts revolutions and keeps sticky faults. Stall detection: RING_STALL_DET_EN.
module ring_monitor import ring_mon_pkg::*; #(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int REV_W     = DEF_REV_W,
    parameter int STALL_LIM = DEF_STALL_LIM
) (
    input logic           clk,
    input logic           rst,
    ring_monitor_if.slave bus
);

    localparam int POS_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 63 || STALL_LIM < 1) begin : g_param_check
        $error("ring_monitor: unsupported WIDTH or STALL_LIM");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_prev;
    logic [POS_W-1:0] r_pos;
    logic             r_pos_valid;
    logic [REV_W-1:0] r_rev_count;
    logic             r_rev_tick;
    logic             r_err_onehot;
    logic             r_err_seq;

    logic             w_onehot;
    logic [POS_W-1:0] w_index;
    logic [WIDTH-1:0] w_rotl_prev;
    logic             w_step;
    logic             w_hold;
    logic             w_tick;
    logic             w_set_err_onehot;
    logic             w_set_err_seq;

`ifdef RING_STALL_DET_EN
    localparam int HOLD_W = $clog2(STALL_LIM + 1);
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_err_stall;
    logic              w_set_err_stall;
`endif

    onehot_enc #(.WIDTH(WIDTH)) u_onehot_enc (
        .i_word   (bus.ring_in),
        .o_onehot (w_onehot),
        .o_index  (w_index)
    );

    assign w_rotl_prev = WIDTH'(rotl(64'(r_prev), WIDTH));
    assign w_step      = (bus.ring_in == w_rotl_prev);
    assign w_hold      = (bus.ring_in == r_prev);

    always_ff @(posedge clk) begin
        if (rst || bus.sync_clr) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A step out of ACQUIRE only locks; revolutions are counted from LOCKED alone.
    always_comb begin
        w_next_state     = r_state;
        w_tick           = 1'b0;
        w_set_err_onehot = 1'b0;
        w_set_err_seq    = 1'b0;
`ifdef RING_STALL_DET_EN
        w_set_err_stall  = 1'b0;
`endif
        case (r_state)
            UNLOCKED: begin
                if (w_onehot) begin
                    w_next_state = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (w_onehot && w_step) begin
                    w_next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (!w_onehot) begin
                    w_next_state     = FAULT;
                    w_set_err_onehot = 1'b1;
                end else if (w_step) begin
                    w_tick = r_prev[WIDTH-1] && bus.ring_in[0];
                end else if (w_hold) begin
`ifdef RING_STALL_DET_EN
                    if (r_hold_cnt == HOLD_W'(STALL_LIM - 1)) begin
                        w_next_state    = FAULT;
                        w_set_err_stall = 1'b1;
                    end
`endif
                end else begin
                    w_next_state  = FAULT;
                    w_set_err_seq = 1'b1;
                end
            end
            FAULT: begin
                w_next_state = FAULT;
            end
            default: begin
                w_next_state = UNLOCKED;
            end
        endcase
    end

    // Position and prev keep tracking legal words in every state, including FAULT.
    always_ff @(posedge clk) begin
        if (rst || bus.sync_clr) begin
            r_prev       <= '0;
            r_pos        <= '0;
            r_pos_valid  <= 1'b0;
            r_rev_count  <= '0;
            r_rev_tick   <= 1'b0;
            r_err_onehot <= 1'b0;
            r_err_seq    <= 1'b0;
        end else begin
            if (w_onehot) begin
                r_prev      <= bus.ring_in;
                r_pos       <= w_index;
                r_pos_valid <= 1'b1;
            end else begin
                r_pos_valid <= 1'b0;
            end
            r_rev_tick <= w_tick;
            if (w_tick) begin
                r_rev_count <= r_rev_count + REV_W'(1);
            end
            if (w_set_err_onehot) begin
                r_err_onehot <= 1'b1;
            end
            if (w_set_err_seq) begin
                r_err_seq <= 1'b1;
            end
        end
    end

`ifdef RING_STALL_DET_EN
    always_ff @(posedge clk) begin
        if (rst || bus.sync_clr) begin
            r_hold_cnt  <= '0;
            r_err_stall <= 1'b0;
        end else begin
            if (r_state == LOCKED && w_hold) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
            if (w_set_err_stall) begin
                r_err_stall <= 1'b1;
            end
        end
    end

    assign bus.err_stall = r_err_stall;
`else
    assign bus.err_stall = 1'b0;
`endif

    assign bus.pos        = r_pos;
    assign bus.pos_valid  = r_pos_valid;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.rev_count  = r_rev_count;
    assign bus.rev_tick   = r_rev_tick;
    assign bus.err_onehot = r_err_onehot;
    assign bus.err_seq    = r_err_seq;

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed scenarios plus a randomized run,
// compared every cycle against an index-based model of the ring rules.
module tb_ring_monitor;

    localparam int STALL_LIM = 4;

    logic       clk = 1'b0;
    logic       tbRst;
    logic       tbSyncClr;
    logic [3:0] tbRingIn;

    int    checks = 0;
    int    errors = 0;
    string stepTag = "init";

    // Reference model state: hot index of the last legal word and coarse flags
    int  mPrevIdx;
    bit  mAnchored;
    bit  mLocked;
    bit  mFault;
    int  mHolds;
    int  mRevs;
    int  ePos;
    bit  eValid;
    bit  eTick;
    bit  eErrOnehot;
    bit  eErrSeq;
    bit  eErrStall;

    always #5 clk = ~clk;

    ring_monitor_if #(.WIDTH(4), .REV_W(8)) busMain ();
    ring_monitor_if #(.WIDTH(4), .REV_W(2)) busSmall ();

    assign busMain.ring_in   = tbRingIn;
    assign busMain.sync_clr  = tbSyncClr;
    assign busSmall.ring_in  = tbRingIn;
    assign busSmall.sync_clr = tbSyncClr;

    ring_monitor #(.WIDTH(4), .REV_W(8), .STALL_LIM(STALL_LIM)) dutMain (
        .clk (clk),
        .rst (tbRst),
        .bus (busMain)
    );

    ring_monitor #(.WIDTH(4), .REV_W(2), .STALL_LIM(STALL_LIM)) dutSmall (
        .clk (clk),
        .rst (tbRst),
        .bus (busSmall)
    );

    task automatic modelStep(input logic [3:0] word, input bit clr, input bit rs);
        int ones;
        int idx;
        bit oneHot;
        bit isStep;
        bit isHold;
        eTick = 1'b0;
        if (rs || clr) begin
            mPrevIdx   = -1;
            mAnchored  = 1'b0;
            mLocked    = 1'b0;
            mFault     = 1'b0;
            mHolds     = 0;
            mRevs      = 0;
            ePos       = 0;
            eValid     = 1'b0;
            eErrOnehot = 1'b0;
            eErrSeq    = 1'b0;
            eErrStall  = 1'b0;
            return;
        end
        ones = 0;
        idx  = 0;
        for (int b = 0; b < 4; b++) begin
            if (word[b]) begin
                ones++;
                idx = b;
            end
        end
        oneHot = (ones == 1);
        isStep = oneHot && (mPrevIdx >= 0) && (idx == (mPrevIdx + 1) % 4);
        isHold = oneHot && (idx == mPrevIdx);
        if (!mFault) begin
            if (mLocked) begin
                if (!oneHot) begin
                    mLocked    = 1'b0;
                    mFault     = 1'b1;
                    eErrOnehot = 1'b1;
                end else if (isStep) begin
                    mHolds = 0;
                    if (idx == 0) begin
                        eTick = 1'b1;
                        mRevs++;
                    end
                end else if (isHold) begin
                    mHolds++;
`ifdef RING_STALL_DET_EN
                    if (mHolds >= STALL_LIM) begin
                        mLocked   = 1'b0;
                        mFault    = 1'b1;
                        eErrStall = 1'b1;
                    end
`endif
                end else begin
                    mLocked = 1'b0;
                    mFault  = 1'b1;
                    eErrSeq = 1'b1;
                end
            end else if (mAnchored) begin
                if (isStep) begin
                    mLocked = 1'b1;
                    mHolds  = 0;
                end
            end else if (oneHot) begin
                mAnchored = 1'b1;
            end
        end
        if (oneHot) begin
            ePos     = idx;
            eValid   = 1'b1;
            mPrevIdx = idx;
        end else begin
            eValid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s at step %s: observed %0h expected %0h",
                   name, stepTag, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("pos",             32'(busMain.pos),        32'(ePos));
        checkOutput("pos_valid",       32'(busMain.pos_valid),  32'(eValid));
        checkOutput("locked",          32'(busMain.locked),     32'(mLocked));
        checkOutput("rev_count",       32'(busMain.rev_count),  32'(mRevs % 256));
        checkOutput("rev_tick",        32'(busMain.rev_tick),   32'(eTick));
        checkOutput("err_onehot",      32'(busMain.err_onehot), 32'(eErrOnehot));
        checkOutput("err_seq",         32'(busMain.err_seq),    32'(eErrSeq));
        checkOutput("err_stall",       32'(busMain.err_stall),  32'(eErrStall));
        checkOutput("small.rev_count", 32'(busSmall.rev_count), 32'(mRevs % 4));
        checkOutput("small.rev_tick",  32'(busSmall.rev_tick),  32'(eTick));
        checkOutput("small.locked",    32'(busSmall.locked),    32'(mLocked));
    endtask

    task automatic applyStimulus(input logic [3:0] word, input bit clr, input bit rs,
                                 input string tag);
        @(negedge clk);
        tbRingIn  = word;
        tbSyncClr = clr;
        tbRst     = rs;
        stepTag   = tag;
        @(posedge clk);
        modelStep(word, clr, rs);
        #1;
        compareAll();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        int lastIdx;
        logic [3:0] word;

        tbRst     = 1'b1;
        tbSyncClr = 1'b0;
        tbRingIn  = 4'b0000;

        applyStimulus(4'b0110, 1'b0, 1'b1, "reset");
        applyStimulus(4'b0000, 1'b0, 1'b1, "reset");

        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'(1 << (k % 4)), 1'b0, 1'b0, "first_rev");
        end

        applyStimulus(4'b0010, 1'b0, 1'b0, "pre_seq_fault");
        applyStimulus(4'b0100, 1'b0, 1'b0, "pre_seq_fault");
        applyStimulus(4'b1000, 1'b0, 1'b0, "pre_seq_fault");
        applyStimulus(4'b0100, 1'b0, 1'b0, "seq_fault");
        applyStimulus(4'b0001, 1'b0, 1'b0, "fault_tracks");
        applyStimulus(4'b0000, 1'b0, 1'b0, "fault_tracks");
        applyStimulus(4'b0010, 1'b0, 1'b0, "fault_tracks");
        applyStimulus(4'b0000, 1'b1, 1'b0, "clear_after_seq");

        applyStimulus(4'b0001, 1'b0, 1'b0, "relock");
        applyStimulus(4'b0010, 1'b0, 1'b0, "relock");
        applyStimulus(4'b0100, 1'b0, 1'b0, "relock");
        applyStimulus(4'b0110, 1'b0, 1'b0, "onehot_fault");
        applyStimulus(4'b1000, 1'b0, 1'b0, "fault_tracks");
        applyStimulus(4'b1000, 1'b1, 1'b0, "clear_after_onehot");

        for (int k = 0; k < 22; k++) begin
            applyStimulus(4'(1 << (k % 4)), 1'b0, 1'b0, "small_wrap");
        end

        applyStimulus(4'b0000, 1'b0, 1'b0, "locked_zero");
        applyStimulus(4'b0001, 1'b1, 1'b0, "clear");
        applyStimulus(4'b0010, 1'b0, 1'b0, "relock");
        applyStimulus(4'b0100, 1'b0, 1'b0, "relock");
        applyStimulus(4'b0110, 1'b1, 1'b1, "rst_and_clr");
        applyStimulus(4'b0000, 1'b0, 1'b0, "after_rst_and_clr");

        applyStimulus(4'b0001, 1'b0, 1'b0, "hold_lock");
        applyStimulus(4'b0010, 1'b0, 1'b0, "hold_lock");
        applyStimulus(4'b0100, 1'b0, 1'b0, "hold_lock");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0, "hold");
        end
        applyStimulus(4'b1000, 1'b0, 1'b0, "after_hold");
        applyStimulus(4'b0000, 1'b1, 1'b0, "clear");

        for (int k = 0; k < 1044; k++) begin
            applyStimulus(4'(1 << (k % 4)), 1'b0, 1'b0, "long_run");
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, "clear");

        for (int n = 0; n < 400; n++) begin
            lastIdx = (mPrevIdx < 0) ? 0 : mPrevIdx;
            r = int'($urandom_range(0, 99));
            if (r < 72) begin
                applyStimulus(4'(1 << ((lastIdx + 1) % 4)), 1'b0, 1'b0, "rand_step");
            end else if (r < 82) begin
                applyStimulus(4'(1 << lastIdx), 1'b0, 1'b0, "rand_hold");
            end else if (r < 94) begin
                word = 4'($urandom_range(0, 15));
                applyStimulus(word, 1'b0, 1'b0, "rand_word");
            end else if (r < 98) begin
                word = 4'($urandom_range(0, 15));
                applyStimulus(word, 1'b1, 1'b0, "rand_clr");
            end else begin
                word = 4'($urandom_range(0, 15));
                applyStimulus(word, 1'b0, 1'b1, "rand_rst");
            end
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_monitor.md
Name: ring_monitor

Overview:
- Downstream consumer of the 4-bit ring counter output.
- Each cycle it checks that the ring word is a legal one-hot pattern, encodes the hot-bit position to binary, and verifies that successive samples follow the rotate-left sequence (bit0→bit1→…→bit3→bit0).
- It counts completed revolutions and raises sticky fault flags.
- Control logic uses it to gate slot-based sequencing on a locked, healthy ring.

Parameters:
- WIDTH, 4: ring width in bits; must be ≥ 2.
- REV_W, 8: width of the revolution counter.
- STALL_LIM, 4: consecutive hold cycles before a stall fault; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on the rising edge (the ring updates on the falling edge, which gives a half-cycle to settle).
- rst  input  1  synchronous, active-high reset.
- ring_in  input  WIDTH  ring counter output word.
- sync_clr  input  1  synchronous clear of faults, lock and revolution count.
- pos  output  $clog2(WIDTH)  binary index of the hot bit.
- pos_valid  output  1  last sample was one-hot.
- locked  output  1  FSM is in LOCKED.
- rev_count  output  REV_W  completed revolutions, modulo 2^REV_W.
- rev_tick  output  1  one-cycle pulse per completed revolution.
- err_onehot  output  1  sticky: a non-one-hot sample was seen.
- err_seq  output  1  sticky: an illegal step was seen while LOCKED.
- err_stall  output  1  sticky: stall fault (optional feature).

Behaviour:
- All outputs are registered, with 1-cycle latency: outputs after edge k reflect ring_in sampled at edge k.
- Reset values: pos=0, pos_valid=0, locked=0, rev_count=0, rev_tick=0, all err_*=0, prev=0, state=UNLOCKED.
- Priority: rst > sync_clr > normal operation. sync_clr has the same effect as rst on every output and on state.
- Definitions:
  - onehot = (popcount(ring_in) == 1).
  - step = (ring_in == rotl(prev, 1)).
  - hold = (ring_in == prev).
- pos / pos_valid:
  - When onehot: pos_valid=1 and pos = index of the set bit.
  - Otherwise: pos_valid=0 and pos holds its last value.
- prev is loaded with ring_in on every onehot sample.
- States and transitions:
  - UNLOCKED: onehot → ACQUIRE. Non-one-hot → stay, no error.
  - ACQUIRE: step → LOCKED. Hold or other onehot → stay. Non-one-hot → stay, no error.
  - LOCKED: step or hold → stay. Other onehot → FAULT, err_seq=1. Non-one-hot → FAULT, err_onehot=1.
  - FAULT: exits only via sync_clr or rst, to UNLOCKED. The FSM ignores ring_in; pos/pos_valid keep tracking.
- locked=1 exactly while in LOCKED.
- Revolution counting:
  - In LOCKED, a step with prev[WIDTH-1]=1 and ring_in[0]=1 gives rev_tick=1 for one cycle and rev_count+1.
  - rev_count wraps from 2^REV_W-1 to 0 without a flag.
  - The ACQUIRE→LOCKED step itself never produces a tick, even on a wrap step.
  - rev_count is frozen in FAULT, UNLOCKED and ACQUIRE.
- ring_in = 0 or multi-hot while LOCKED faults in the same edge; simultaneous fault conditions set every applicable flag.
- Reset or sync_clr mid-revolution discards partial progress; re-acquisition requires a fresh onehot followed by a step.

Optional Feature:
- Macro: RING_STALL_DET_EN.
- Defined:
  - A hold counter increments on each hold sample while LOCKED and clears on a step.
  - When the count reaches STALL_LIM, on that edge: state → FAULT and err_stall=1.
- Undefined:
  - No counter is built; err_stall is tied 0 and holds are tolerated indefinitely.
  - The port list is identical in both builds.

Decomposition:
- Package ring_mon_pkg holds:
  - the state encoding (UNLOCKED=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, FAULT=2'd3);
  - default WIDTH/REV_W/STALL_LIM constants;
  - a rotl helper function.
- Sub-module onehot_enc (combinational, WIDTH-parameterised) outputs the onehot flag and the binary index. It is instantiated once.

Test Plan:
- rst, then ring_in 0001,0010,0100,1000,0001 per cycle → locked=1 after the 0010 sample; one rev_tick on the 1000→0001 edge; rev_count=1; pos sequence 0,1,2,3,0.
- Locked ring, 1000 then 0100 → err_seq=1, locked=0; rev_count frozen; pos_valid stays 1.
- Locked ring, 0110 injected → err_onehot=1, pos_valid=0, pos holds previous value; then sync_clr → all flags 0, rev_count=0, state UNLOCKED.
- REV_W=2, run 5 revolutions → rev_count goes 1,2,3,0,1 with 5 rev_tick pulses.
- rst and sync_clr asserted together with a mid-sequence fault pattern → reset values next cycle, no flag set.
- RING_STALL_DET_EN, STALL_LIM=4, locked ring held at 0100 → err_stall=1 on the 4th hold sample. Without the macro, the same stimulus leaves locked=1 and err_stall=0.
